uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority voting, optional parity, one or two stop
// bits, a one-word holding register with ready/valid handshake, and line-break detection.
module uart_rx_cfg #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                data_len,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      two_stop,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      overrun,
  output logic                      break_detect
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
  } state_e;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  state_e                    state_q;
  logic [PRESCALE_WIDTH-1:0] edge_q, pre_q, half;
  logic [3:0]                bit_cnt_q, len_q, shamt;
  logic                      par_en_q, par_type_q, two_q;
  logic [DATA_WIDTH-1:0]     shift_q, data_q;
  logic [2:0]                samp_q;
  logic                      par_acc_q, zero_q, perr_q, ferr_q;
  logic                      dv_q, pe_out_q, fe_out_q, ovr_q, brk_q;
  logic                      samp0, samp1, samp2, decide, wrap, maj;
  logic                      brk_hit, done, ferr_final;

  // Synchroniser chain; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= RX_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Sample points around the bit centre and the decision point one count later.
  always_comb begin
    half   = pre_q >> 1;
    samp0  = (edge_q == half - PRESCALE_WIDTH'(2));
    samp1  = (edge_q == half - PRESCALE_WIDTH'(1));
    samp2  = (edge_q == half);
    decide = (edge_q == half + PRESCALE_WIDTH'(1));
    wrap   = (edge_q == pre_q - PRESCALE_WIDTH'(1));
    maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    shamt  = 4'(DATA_WIDTH) - len_q;
    // Break wins over word delivery: everything low through the first stop bit.
    brk_hit    = (state_q == StStop1) && decide && zero_q && !maj;
    done       = decide && !brk_hit &&
                 (((state_q == StStop1) && !two_q) || (state_q == StStop2));
    ferr_final = (state_q == StStop2) ? (ferr_q | !maj) : !maj;
  end

  // Receive FSM, counters, holding register and output flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      edge_q     <= '0;
      pre_q      <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      two_q      <= 1'b0;
      shift_q    <= '0;
      samp_q     <= '1;
      par_acc_q  <= 1'b0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      pe_out_q   <= 1'b0;
      fe_out_q   <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      brk_q <= 1'b0;
      if (dv_q && out_ready) dv_q <= 1'b0;
      if (done) begin
        if (!dv_q || out_ready) begin
          data_q   <= shift_q >> shamt;
          pe_out_q <= perr_q;
          fe_out_q <= ferr_final;
          dv_q     <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
      if (brk_hit) brk_q <= 1'b1;

      if (samp0) samp_q[0] <= rx_s;
      if (samp1) samp_q[1] <= rx_s;
      if (samp2) samp_q[2] <= rx_s;

      if (state_q != StIdle && state_q != StBrkWait) begin
        edge_q <= wrap ? '0 : edge_q + PRESCALE_WIDTH'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q    <= StStart;
            edge_q     <= '0;
            pre_q      <= Prescale;
            len_q      <= data_len;
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
            two_q      <= two_stop;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            zero_q     <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        StStart: begin
          if (decide && maj) state_q <= StIdle;
          else if (wrap)     state_q <= StData;
        end
        StData: begin
          if (decide) begin
            shift_q   <= {maj, shift_q[DATA_WIDTH-1:1]};
            par_acc_q <= par_acc_q ^ maj;
            zero_q    <= zero_q & !maj;
          end
          if (wrap) begin
            if (bit_cnt_q == len_q - 4'd1) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? StParity : StStop1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (decide) begin
            perr_q <= (par_acc_q ^ par_type_q) != maj;
            zero_q <= zero_q & !maj;
          end
          if (wrap) state_q <= StStop1;
        end
        StStop1: begin
          if (decide) begin
            ferr_q <= !maj;
            if (brk_hit)     state_q <= StBrkWait;
            else if (!two_q) state_q <= StIdle;
          end else if (wrap && two_q) begin
            state_q <= StStop2;
          end
        end
        StStop2: begin
          if (decide) state_q <= StIdle;
        end
        StBrkWait: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign P_DATA        = data_q;
  assign data_valid    = dv_q;
  assign parity_error  = pe_out_q;
  assign framing_error = fe_out_q;
  assign overrun       = ovr_q;
  assign break_detect  = brk_q;

endmodule
